// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage pipeline.
// Takes the EX/MEM register outputs, performs byte/halfword/word loads and
// stores on a req/ack data bus, and drives the write-back channel into MEM/WB.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   mem_write_reg_*_i         write-back channel from EX/MEM (data = effective
//                             address for memory ops)
//   mem_op_i                  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW,
//                             6 SB, 7 SH, 8 SW, 9..15 behave as NONE
//   mem_store_data_i          store source data
//   wb_write_reg_*_o          write-back channel into MEM/WB
//   stall_req_o               holds the pipeline while an access is in flight
//   align_err_o               misaligned access (combinational)
//   bus_err_o                 high in DONE when the access timed out
//   dbus_*                    registered data-bus request; rdata/ack inputs
`timescale 1ns/1ps

module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write_reg_en_i,
  input  logic [4:0]  mem_write_reg_addr_i,
  input  logic [31:0] mem_write_reg_data_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_store_data_i,
  output logic        wb_write_reg_en_o,
  output logic [4:0]  wb_write_reg_addr_o,
  output logic [31:0] wb_write_reg_data_o,
  output logic        stall_req_o,
  output logic        align_err_o,
  output logic        bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i
);

  localparam int unsigned CNT_W = 10;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             bus_err_q;
  logic [31:0]      load_q;

  logic        is_load;
  logic        is_store;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        mem_ok;
  logic [1:0]  lane;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_fmt;
  logic        timeout_hit;

  // Operation decode and misalignment check
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    unique case (mem_op_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
      OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
      default:       ;
    endcase
    lane       = mem_write_reg_data_i[1:0];
    misaligned = (is_half && lane[0]) || (is_word && (lane != 2'd0));
    mem_ok     = (is_load || is_store) && !misaligned;
  end

  // Byte-enable and store-data lane steering (little-endian)
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = mem_store_data_i;
    if (is_byte) begin
      req_be    = 4'(4'b0001 << lane);
      req_wdata = {4{mem_store_data_i[7:0]}};
    end else if (is_half) begin
      req_be    = lane[1] ? 4'b1100 : 4'b0011;
      req_wdata = {2{mem_store_data_i[15:0]}};
    end
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    rd_byte = dbus_rdata_i[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    unique case (mem_op_i)
      OP_LB:   load_fmt = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_fmt = {24'd0, rd_byte};
      OP_LH:   load_fmt = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_fmt = {16'd0, rd_half};
      default: load_fmt = dbus_rdata_i;
    endcase
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Bus FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bus_err_q    <= 1'b0;
      load_q       <= '0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          bus_err_q <= 1'b0;
          if (mem_ok) begin
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= is_store;
            dbus_addr_o  <= {mem_write_reg_data_i[31:2], 2'b00};
            dbus_be_o    <= req_be;
            dbus_wdata_o <= req_wdata;
            cnt          <= '0;
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // An ack in the last allowed cycle still completes normally
          if (dbus_ack_i) begin
            dbus_req_o <= 1'b0;
            load_q     <= load_fmt;
            state      <= ST_DONE;
          end else if (timeout_hit) begin
            dbus_req_o <= 1'b0;
            bus_err_q  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus_err_q <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus_err_o   = bus_err_q;
  assign align_err_o = misaligned;

  // Write-back channel and stall request
  always_comb begin
    wb_write_reg_en_o   = mem_write_reg_en_i;
    wb_write_reg_addr_o = mem_write_reg_addr_i;
    wb_write_reg_data_o = mem_write_reg_data_i;
    stall_req_o         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (misaligned) begin
          wb_write_reg_en_o = 1'b0;
        end else if (mem_ok) begin
          wb_write_reg_en_o = 1'b0;
          stall_req_o       = 1'b1;
        end
      end
      ST_BUSY: begin
        wb_write_reg_en_o = 1'b0;
        stall_req_o       = 1'b1;
      end
      ST_DONE: begin
        if (is_load) begin
          wb_write_reg_en_o   = mem_write_reg_en_i && !bus_err_q;
          wb_write_reg_data_o = load_q;
        end
      end
      default: wb_write_reg_en_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps

module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        mem_write_reg_en_i;
  logic [4:0]  mem_write_reg_addr_i;
  logic [31:0] mem_write_reg_data_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_store_data_i;
  logic        wb_write_reg_en_o;
  logic [4:0]  wb_write_reg_addr_o;
  logic [31:0] wb_write_reg_data_o;
  logic        stall_req_o;
  logic        align_err_o;
  logic        bus_err_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic [31:0] dbus_rdata_i;
  logic        dbus_ack_i;

  int total = 0;
  int bad   = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_write_reg_en_i   (mem_write_reg_en_i),
    .mem_write_reg_addr_i (mem_write_reg_addr_i),
    .mem_write_reg_data_i (mem_write_reg_data_i),
    .mem_op_i             (mem_op_i),
    .mem_store_data_i     (mem_store_data_i),
    .wb_write_reg_en_o    (wb_write_reg_en_o),
    .wb_write_reg_addr_o  (wb_write_reg_addr_o),
    .wb_write_reg_data_o  (wb_write_reg_data_o),
    .stall_req_o          (stall_req_o),
    .align_err_o          (align_err_o),
    .bus_err_o            (bus_err_o),
    .dbus_req_o           (dbus_req_o),
    .dbus_we_o            (dbus_we_o),
    .dbus_addr_o          (dbus_addr_o),
    .dbus_be_o            (dbus_be_o),
    .dbus_wdata_o         (dbus_wdata_o),
    .dbus_rdata_i         (dbus_rdata_i),
    .dbus_ack_i           (dbus_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access: inputs, ack cycle (0 = never) and expected results
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic        en;
    logic [31:0] sd;
    logic [31:0] rd;
    int          ack_at;
    logic        exp_align;
    int          exp_stall;
    logic [3:0]  exp_be;
    logic [31:0] exp_daddr;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_wb_en;
    logic [31:0] exp_wb_data;
    logic        exp_berr;
  } vec_t;

  typedef struct {
    logic        align;
    int          stall;
    logic        req_seen;
    logic [3:0]  be;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic        we;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        berr;
    logic        req_after;
    logic        stall_after;
    logic        hung;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model from the access rules, using plain arithmetic
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr, input logic en,
                                 input logic [31:0] sd, input logic [31:0] rd, input int ack_at);
    vec_t v;
    int size;
    bit ld, st, sgn, to;
    logic [31:0] mask, val, off;
    v = '{op: op, addr: addr, en: en, sd: sd, rd: rd, ack_at: ack_at, exp_align: 1'b0,
          exp_stall: 0, exp_be: 4'd0, exp_daddr: 32'd0, exp_wdata: 32'd0, exp_we: 1'b0,
          exp_wb_en: en, exp_wb_data: addr, exp_berr: 1'b0};
    size = 0; ld = 0; st = 0; sgn = 0;
    case (op)
      4'd1: begin ld = 1; size = 1; sgn = 1; end
      4'd2: begin ld = 1; size = 1; end
      4'd3: begin ld = 1; size = 2; sgn = 1; end
      4'd4: begin ld = 1; size = 2; end
      4'd5: begin ld = 1; size = 4; end
      4'd6: begin st = 1; size = 1; end
      4'd7: begin st = 1; size = 2; end
      4'd8: begin st = 1; size = 4; end
      default: ;
    endcase
    if (!(ld || st)) return v;
    off = addr % 4;
    if ((addr % size) != 0) begin
      v.exp_align = 1'b1;
      v.exp_wb_en = 1'b0;
      return v;
    end
    to = (ack_at == 0) || (ack_at > TO);
    v.exp_stall = 1 + (to ? TO : ack_at);
    v.exp_be    = 4'(((1 << size) - 1) << off);
    v.exp_daddr = addr - off;
    v.exp_we    = st;
    v.exp_berr  = to;
    if (size == 1)      v.exp_wdata = sd[7:0] * 32'h0101_0101;
    else if (size == 2) v.exp_wdata = sd[15:0] * 32'h0001_0001;
    else                v.exp_wdata = sd;
    if (ld) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
      val  = (rd >> (8 * off)) & mask;
      if (sgn && (val >= (32'd1 << (8 * size - 1)))) val = val - (32'd1 << (8 * size));
      v.exp_wb_data = val;
      v.exp_wb_en   = en && !to;
    end
    return v;
  endfunction

  // Drive one access from IDLE, return observations, leave the DUT back in IDLE
  task automatic run_access(input vec_t v, input logic [4:0] wa, output obs_t o);
    int busy_k, guard;
    @(posedge clk); #1;
    mem_op_i = v.op; mem_write_reg_data_i = v.addr; mem_write_reg_en_i = v.en;
    mem_write_reg_addr_i = wa; mem_store_data_i = v.sd; dbus_rdata_i = v.rd; dbus_ack_i = 1'b0;
    o = '{align: 1'b0, stall: 0, req_seen: 1'b0, be: 4'd0, daddr: 32'd0, wdata: 32'd0,
          we: 1'b0, wb_en: 1'b0, wb_addr: 5'd0, wb_data: 32'd0, berr: 1'b0,
          req_after: 1'b0, stall_after: 1'b0, hung: 1'b0};
    busy_k = 0; guard = 0;
    @(negedge clk);
    o.align = align_err_o;
    while (stall_req_o && guard < 20) begin
      o.stall++;
      if (dbus_req_o) begin
        o.req_seen = 1'b1; o.be = dbus_be_o; o.daddr = dbus_addr_o;
        o.wdata = dbus_wdata_o; o.we = dbus_we_o;
      end
      @(posedge clk); #1;
      if (dbus_req_o) begin
        busy_k++;
        dbus_ack_i = (busy_k == v.ack_at);
      end else begin
        dbus_ack_i = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    o.hung     = (guard >= 20);
    o.wb_en    = wb_write_reg_en_o;
    o.wb_addr  = wb_write_reg_addr_o;
    o.wb_data  = wb_write_reg_data_o;
    o.berr     = bus_err_o;
    o.req_seen = o.req_seen | dbus_req_o;
    @(posedge clk); #1;
    dbus_ack_i = 1'b0; mem_op_i = 4'd0; mem_write_reg_en_i = 1'b0;
    @(negedge clk);
    o.req_after   = dbus_req_o;
    o.stall_after = stall_req_o;
  endtask

  task automatic compare(input string tag, input vec_t v, input logic [4:0] wa, input obs_t o);
    if (o.hung) begin
      total++; bad++;
      $display("FAIL %s stall: still stalled after 20 cycles, required %0d", tag, v.exp_stall);
    end
    chk({tag, " align"}, 32'(o.align), 32'(v.exp_align));
    chk({tag, " stall_cycles"}, 32'(o.stall), 32'(v.exp_stall));
    chk({tag, " wb_en"}, 32'(o.wb_en), 32'(v.exp_wb_en));
    chk({tag, " req_after"}, 32'(o.req_after), 32'd0);
    chk({tag, " stall_after"}, 32'(o.stall_after), 32'd0);
    if (v.exp_stall > 0) begin
      chk({tag, " be"}, 32'(o.be), 32'(v.exp_be));
      chk({tag, " daddr"}, o.daddr, v.exp_daddr);
      chk({tag, " we"}, 32'(o.we), 32'(v.exp_we));
      chk({tag, " bus_err"}, 32'(o.berr), 32'(v.exp_berr));
      chk({tag, " wb_addr"}, 32'(o.wb_addr), 32'(wa));
      if (v.exp_we) chk({tag, " wdata"}, o.wdata, v.exp_wdata);
      if (!v.exp_berr) chk({tag, " wb_data"}, o.wb_data, v.exp_wb_data);
    end else begin
      chk({tag, " req_seen"}, 32'(o.req_seen), 32'd0);
      chk({tag, " bus_err"}, 32'(o.berr), 32'd0);
      if (!v.exp_align) begin
        chk({tag, " wb_addr"}, 32'(o.wb_addr), 32'(wa));
        chk({tag, " wb_data"}, o.wb_data, v.exp_wb_data);
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    obs_t o;
    vec_t v;
    logic [4:0] wa;
    int busy_seen;

    // op addr en sd rd ack | align stall be daddr wdata we wb_en wb_data berr
    tbl.push_back('{4'd0, 32'h1234, 1'b1, 32'h0, 32'h0, 0, 1'b0, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234, 1'b0});
    tbl.push_back('{4'd12, 32'h55, 1'b1, 32'h0, 32'h0, 0, 1'b0, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55, 1'b0});
    tbl.push_back('{4'd5, 32'h301, 1'b1, 32'h0, 32'h0, 1, 1'b1, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h301, 1'b0});
    tbl.push_back('{4'd3, 32'h103, 1'b1, 32'h0, 32'h0, 1, 1'b1, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h103, 1'b0});
    tbl.push_back('{4'd8, 32'h102, 1'b1, 32'h0, 32'h0, 1, 1'b1, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h102, 1'b0});
    tbl.push_back('{4'd1, 32'h103, 1'b1, 32'h0, 32'h80FF_FF7F, 2, 1'b0, 3, 4'h8, 32'h100, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0});
    tbl.push_back('{4'd2, 32'h103, 1'b1, 32'h0, 32'h80FF_FF7F, 2, 1'b0, 3, 4'h8, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0000_0080, 1'b0});
    tbl.push_back('{4'd7, 32'h202, 1'b1, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 2, 4'hC, 32'h200, 32'hBEEF_BEEF, 1'b1, 1'b1, 32'h202, 1'b0});
    tbl.push_back('{4'd3, 32'h102, 1'b1, 32'h0, 32'h8001_7FFF, 3, 1'b0, 4, 4'hC, 32'h100, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001, 1'b0});
    tbl.push_back('{4'd4, 32'h100, 1'b1, 32'h0, 32'h8001_F00D, 1, 1'b0, 2, 4'h3, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0000_F00D, 1'b0});
    tbl.push_back('{4'd6, 32'h101, 1'b1, 32'h0000_00A5, 32'h0, 1, 1'b0, 2, 4'h2, 32'h100, 32'hA5A5_A5A5, 1'b1, 1'b1, 32'h101, 1'b0});
    tbl.push_back('{4'd8, 32'h10C, 1'b1, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 3, 4'hF, 32'h10C, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h10C, 1'b0});
    tbl.push_back('{4'd5, 32'h300, 1'b1, 32'h0, 32'h1234_5678, 4, 1'b0, 5, 4'hF, 32'h300, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0});
    tbl.push_back('{4'd5, 32'h400, 1'b1, 32'h0, 32'h1111_2222, 0, 1'b0, 5, 4'hF, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1});
    tbl.push_back('{4'd1, 32'h002, 1'b1, 32'h0, 32'h00AB_0000, 1, 1'b0, 2, 4'h4, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFAB, 1'b0});

    rst = 1'b0; mem_write_reg_en_i = 1'b0; mem_write_reg_addr_i = 5'd0;
    mem_write_reg_data_i = 32'd0; mem_op_i = 4'd0; mem_store_data_i = 32'd0;
    dbus_rdata_i = 32'd0; dbus_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst req", 32'(dbus_req_o), 32'd0);
    chk("rst we", 32'(dbus_we_o), 32'd0);
    chk("rst addr", dbus_addr_o, 32'd0);
    chk("rst be", 32'(dbus_be_o), 32'd0);
    chk("rst wdata", dbus_wdata_o, 32'd0);
    chk("rst berr", 32'(bus_err_o), 32'd0);
    chk("rst stall", 32'(stall_req_o), 32'd0);

    // Directed table
    foreach (tbl[i]) begin
      run_access(tbl[i], 5'd5, o);
      compare($sformatf("tbl%0d", i), tbl[i], 5'd5, o);
    end

    // Acks in IDLE are ignored
    @(posedge clk); #1;
    mem_op_i = 4'd0; mem_write_reg_en_i = 1'b1; mem_write_reg_addr_i = 5'd9;
    mem_write_reg_data_i = 32'h0BAD_CAFE; dbus_rdata_i = 32'hFFFF_FFFF; dbus_ack_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack req", 32'(dbus_req_o), 32'd0);
      chk("idle_ack stall", 32'(stall_req_o), 32'd0);
      chk("idle_ack wb_data", wb_write_reg_data_o, 32'h0BAD_CAFE);
    end
    @(posedge clk); #1 dbus_ack_i = 1'b0; mem_write_reg_en_i = 1'b0;

    // Reset in the middle of BUSY
    @(posedge clk); #1;
    mem_op_i = 4'd5; mem_write_reg_en_i = 1'b1; mem_write_reg_addr_i = 5'd3;
    mem_write_reg_data_i = 32'h500; dbus_rdata_i = 32'h7777_7777;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst req_before", 32'(dbus_req_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; mem_op_i = 4'd0; mem_write_reg_en_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst req", 32'(dbus_req_o), 32'd0);
    chk("midrst stall", 32'(stall_req_o), 32'd0);
    chk("midrst addr", dbus_addr_o, 32'd0);
    @(posedge clk); #1 dbus_ack_i = 1'b1;
    @(negedge clk);
    chk("midrst late_ack wb_en", 32'(wb_write_reg_en_o), 32'd0);
    chk("midrst late_ack stall", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1 dbus_ack_i = 1'b0;
    @(negedge clk);
    chk("midrst late_ack req", 32'(dbus_req_o), 32'd0);
    chk("midrst late_ack berr", 32'(bus_err_o), 32'd0);

    // Randomized accesses against the model
    busy_seen = 0;
    for (int i = 0; i < 60; i++) begin
      v  = model(4'($urandom_range(0, 15)), $urandom, 1'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 5)));
      wa = 5'($urandom);
      if (v.exp_stall > 0) busy_seen++;
      run_access(v, wa, o);
      compare($sformatf("rnd%0d", i), v, wa, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage pipeline; consumes the EX/MEM register outputs, performs loads and stores on the data bus, and drives the write-back channel into the MEM/WB register.
- Handles byte, halfword and word accesses, little-endian lane steering, load sign/zero extension and misalignment detection.
- A req/ack bus FSM with timeout stalls the pipeline while an access is outstanding.

Parameters:
- TIMEOUT, 255: maximum number of BUSY cycles without dbus_ack_i before the access is aborted; range 1..1023.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (0 = reset)
- mem_write_reg_en_i  in  1  write-back enable from EX/MEM
- mem_write_reg_addr_i  in  5  destination register
- mem_write_reg_data_i  in  32  ALU result; for memory ops, the effective address
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9..15 treated as NONE
- mem_store_data_i  in  32  store source data
- wb_write_reg_en_o  out  1  to MEM/WB
- wb_write_reg_addr_o  out  5  to MEM/WB
- wb_write_reg_data_o  out  32  to MEM/WB
- stall_req_o  out  1  pipeline stall request
- align_err_o  out  1  misaligned access flag (combinational)
- bus_err_o  out  1  timeout pulse
- dbus_req_o  out  1  bus request (registered)
- dbus_we_o  out  1  1 = write (registered)
- dbus_addr_o  out  32  word-aligned address, low 2 bits 0 (registered)
- dbus_be_o  out  4  byte enables (registered)
- dbus_wdata_o  out  32  write data (registered)
- dbus_rdata_i  in  32  read data, valid with ack
- dbus_ack_i  in  1  access complete

Behaviour:
- Reset (rst=0 at posedge): state IDLE; dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, load result register, timeout counter and bus_err_o all 0. Reset asserted mid-access drops dbus_req_o at that edge; later acks are ignored.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. align_err_o=1, no bus request, stall_req_o=0, wb_write_reg_en_o forced 0. Byte accesses are never misaligned.
- FSM states: IDLE, BUSY, DONE.
- IDLE, op NONE: pure pass-through. wb_* = mem_write_reg_*_i, stall_req_o=0.
- IDLE, aligned memory op: stall_req_o=1. At the next edge, register the dbus_* signals, set dbus_req_o=1 and go to BUSY.
- BUSY: stall_req_o=1. All dbus_* outputs stay stable. The counter increments each cycle.
  - dbus_ack_i=1 sampled: dbus_req_o drops, the formatted load result is captured, go to DONE.
  - Counter reaches TIMEOUT with no ack: dbus_req_o drops, bus_err_flag set, go to DONE.
- DONE (exactly 1 cycle): stall_req_o=0 and wb_* valid. bus_err_o=1 only if aborted. Always go to IDLE.
- Write-back data in DONE: loads output the captured result with wb_write_reg_en_o = input enable, forced to 0 on abort. Stores pass the inputs through.
- Upstream holds all inputs stable while stall_req_o=1. The pipeline advances on the DONE edge.
- Latency: a memory op with ack in the first BUSY cycle takes 3 cycles (IDLE, BUSY, DONE). Each later ack adds 1 cycle.
- Lanes (n = addr[1:0]):
  - Byte: be = 1<<n, data bits [8n+7:8n].
  - Halfword: addr[1]=0 gives be 0011, bits [15:0]; addr[1]=1 gives be 1100, bits [31:16].
  - Word: be 1111.
- Store data: SB replicates the byte into all 4 lanes; SH replicates the halfword into both halves; SW passes through. dbus_we_o=1 for stores.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- dbus_ack_i in IDLE or DONE is ignored. dbus_rdata_i is sampled only on an ack in BUSY.
- The counter clears on entry to BUSY.

Test Plan:
- ALU op pass-through: op=NONE, en=1, addr=5, data=0x1234 -> same-cycle wb = (1, 5, 0x1234), stall_req_o=0, dbus_req_o never 1.
- LB sign extension: addr=0x103, rdata=0x80FF_FF7F, ack in the 2nd BUSY cycle -> be=1000, dbus_addr=0x100, stall 3 cycles, DONE wb_data=0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH: addr=0x202, store_data=0xDEADBEEF -> we=1, be=1100, wdata=0xBEEFBEEF, dbus_addr=0x200; on ack, DONE, then IDLE.
- LW at 0x301 -> align_err_o=1, no request, wb_write_reg_en_o=0, stall_req_o=0.
- Timeout: TIMEOUT=4, LW with no ack -> exactly 4 BUSY cycles, then DONE with bus_err_o=1 and wb_write_reg_en_o=0, then IDLE.
- Reset mid-BUSY: rst=0 -> dbus_req_o=0 at the next edge, state IDLE; an ack asserted afterwards produces no write-back.
